glyph_fetch_unit: RTL

//  Upstream feeder of the display controller. Host pushes character codes into a small FIFO;
//  on an advance pulse the next code becomes the displayed character. Each controller read

---
 rtl/glyph_fetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/glyph_fetch_unit.sv
// Character FIFO feeding the displayed-glyph register, plus a two-stage
// character-ROM fetch pipeline that returns one glyph row per request.
module glyph_fetch_unit #(
  parameter int CODE_W     = 7,
  parameter int ROW_W      = 4,
  parameter int BYTE_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CODE_W-1:0]        hostChar,
  input  logic                     hostValid,
  output logic                     hostReady,
  input  logic                     advance,
  input  logic                     readEn,
  input  logic [ROW_W-1:0]         addOffset,
  output logic [CODE_W+ROW_W-1:0]  romAddr,
  input  logic [BYTE_W-1:0]        romData,
  output logic [BYTE_W-1:0]        romByte,
  output logic [CODE_W-1:0]        curChar,
  output logic                     charValid,
  output logic [CNT_W-1:0]         fifoCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {EMPTY, SHOW} state_e;

  logic [FIFO_DEPTH-1:0][CODE_W-1:0] mem_q;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic [CODE_W-1:0] char_q, char_d;
  logic [CODE_W+ROW_W-1:0] addr_q;
  logic [BYTE_W-1:0] byte_q;
  logic              req_q;       // a request was issued last cycle
  logic              req_vld_q;   // ...and a character was loaded at that time
  logic              push, pop;

  assign hostReady = (cnt_q != CNT_W'(FIFO_DEPTH));
  assign push      = hostValid & hostReady;
  assign pop       = advance & (cnt_q != '0);

  // FIFO storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= hostChar;
  end

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    char_d  = char_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop) begin
      rd_d    = rd_q + 1'b1;
      char_d  = mem_q[rd_q];
      state_d = SHOW;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      state_q <= EMPTY;
      char_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      char_q  <= char_d;
    end
  end

  // Fetch pipeline: address stage uses the pre-advance character; data stage
  // substitutes a blank row when no character had been loaded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      req_q     <= 1'b0;
      req_vld_q <= 1'b0;
      byte_q    <= '0;
    end else begin
      req_q     <= readEn;
      req_vld_q <= readEn & (state_q == SHOW);
      if (readEn) addr_q <= {char_q, addOffset};
      if (req_q)  byte_q <= req_vld_q ? romData : '0;
    end
  end

  assign romAddr   = addr_q;
  assign romByte   = byte_q;
  assign curChar   = char_q;
  assign charValid = (state_q == SHOW);
  assign fifoCount = cnt_q;

endmodule
